// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit: shift-add multiply and restoring
// divide, one iteration per cycle, result presented with a one-cycle write pulse.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       dest_reg,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_reg
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpMulhu = 2'b01;
  localparam logic [1:0] OpDivu  = 2'b10;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         dest_q, dest_d;
  logic [4:0]         result_reg_q, result_reg_d;

  // Multiply step: multiplier sits in the low half of prod and shifts out LSB-first.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] prod_step;

  // Divide step: a_q shifts dividend bits out MSB-first and quotient bits in.
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  always_comb begin
    add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_step = {add_sum, prod_q[WIDTH-1:1]};
    rem_shift = {rem_q, a_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, b_q};
    // When rem_ge holds the true difference is below b_q, so WIDTH bits suffice.
    rem_step  = rem_ge ? (rem_shift[WIDTH-1:0] - b_q) : rem_shift[WIDTH-1:0];
    quo_step  = {a_q[WIDTH-2:0], rem_ge};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    prod_d       = prod_q;
    rem_d        = rem_q;
    result_d     = result_q;
    dest_d       = dest_q;
    result_reg_d = result_reg_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          state_d = StRun;
          cnt_d   = '0;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          dest_d  = dest_reg;
          prod_d  = {{WIDTH{1'b0}}, src_b};
          rem_d   = '0;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (op_q[1]) begin
            rem_d = rem_step;
            a_d   = quo_step;
          end else begin
            prod_d = prod_step;
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(WIDTH - 1)) begin
            state_d      = StDone;
            result_reg_d = dest_q;
            unique case (op_q)
              OpMul:   result_d = prod_step[WIDTH-1:0];
              OpMulhu: result_d = prod_step[2*WIDTH-1:WIDTH];
              OpDivu:  result_d = quo_step;
              default: result_d = rem_step;
            endcase
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      prod_q       <= '0;
      rem_q        <= '0;
      result_q     <= '0;
      dest_q       <= '0;
      result_reg_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      prod_q       <= prod_d;
      rem_q        <= rem_d;
      result_q     <= result_d;
      dest_q       <= dest_d;
      result_reg_q <= result_reg_d;
    end
  end

  // A flush in the DONE cycle suppresses the register-file write.
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone) && !flush;
  assign result     = result_q;
  assign result_reg = result_reg_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal expectations plus
// randomized traffic compared every cycle against a latency/arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  dest_reg;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_reg;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .dest_reg   (dest_reg),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .result_reg (result_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: age counts edges since acceptance; 33 means the result cycle.
  int          age;
  int          completions;
  logic [31:0] pend_res;
  logic [4:0]  pend_reg;
  logic [31:0] exp_result;
  logic [4:0]  exp_reg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age        = 0;
      exp_result = '0;
      exp_reg    = '0;
    end else if (age == 0) begin
      if (start && !flush) begin
        age      = 1;
        pend_res = model_result(op, src_a, src_b);
        pend_reg = dest_reg;
      end
    end else if (flush || age == 33) begin
      age = 0;
    end else begin
      age++;
      if (age == 33) begin
        exp_result = pend_res;
        exp_reg    = pend_reg;
        completions++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("model_busy", 32'(busy), 32'(age != 0));
      chk("model_done", 32'(done), 32'(age == 33 && !flush));
      chk("model_result", result, exp_result);
      chk("model_result_reg", 32'(result_reg), 32'(exp_reg));
    end
  end

  // Issues one request and waits (bounded) for done; lat counts edges from E0 inclusive.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; dest_reg = rd;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    dest_reg = 5'($urandom);
    lat = 1;
    while (lat < 40 && !done) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  logic [31:0] r;
  int          lat;
  int          ndone;
  int          busy_gap;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    src_a = '0; src_b = '0; dest_reg = '0;
    age = 0; completions = 0; exp_result = '0; exp_reg = '0;
    pend_res = '0; pend_reg = '0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_result_reg", 32'(result_reg), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(2'b00, 32'd7, 32'd6, 5'd5, r, lat);
    chk("mul_7x6", r, 32'd42);
    chk("mul_7x6_latency", 32'(lat), 32'd33);
    chk("mul_7x6_reg", 32'(result_reg), 32'd5);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, r, lat);
    chk("mul_ones", r, 32'h0000_0001);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, r, lat);
    chk("mulhu_ones", r, 32'hFFFF_FFFE);
    run_op(2'b10, 32'd100, 32'd7, 5'd3, r, lat);
    chk("divu_100_7", r, 32'd14);
    run_op(2'b11, 32'd100, 32'd7, 5'd4, r, lat);
    chk("remu_100_7", r, 32'd2);
    run_op(2'b10, 32'h8000_0000, 32'd1, 5'd6, r, lat);
    chk("divu_msb_1", r, 32'h8000_0000);
    run_op(2'b10, 32'd123, 32'd0, 5'd7, r, lat);
    chk("divu_by_zero", r, 32'hFFFF_FFFF);
    chk("divu_by_zero_latency", 32'(lat), 32'd33);
    run_op(2'b11, 32'd123, 32'd0, 5'd8, r, lat);
    chk("remu_by_zero", r, 32'd123);
    chk("remu_by_zero_latency", 32'(lat), 32'd33);

    // Handshake: a second start at E10 must be dropped.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd4; dest_reg = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; busy_gap = 0;
    if (!busy) busy_gap++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 9) begin
        start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9; dest_reg = 5'd10;
      end
      if (k == 10) start = 1'b0;
      if (done) ndone++;
      if (k <= 32 && !busy) busy_gap++;
    end
    chk("hs_done_count", 32'(ndone), 32'd1);
    chk("hs_result", result, 32'd12);
    chk("hs_result_reg", 32'(result_reg), 32'd9);
    chk("hs_busy_gaps", 32'(busy_gap), 32'd0);

    // Flush sampled at E15 during a divide.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3; dest_reg = 5'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_result_kept", result, 32'd12);

    // start with flush in IDLE is not accepted.
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd1; src_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-run.
    start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd5; dest_reg = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_result_reg", 32'(result_reg), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_op(2'b00, 32'd2, 32'd3, 5'd13, r, lat);
    chk("mul_after_rst", r, 32'd6);

    // Random traffic, checked every cycle by the model.
    completions = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      start = ($urandom % 3) == 0;
      flush = ($urandom % 200) == 0;
      op    = 2'($urandom);
      case ($urandom % 4)
        0: src_a = $urandom % 256;
        1: src_a = 32'hFFFF_FFFF;
        default: src_a = $urandom;
      endcase
      case ($urandom % 5)
        0: src_b = 32'd0;
        1: src_b = $urandom % 16;
        2: src_b = 32'hFFFF_FFFF;
        default: src_b = $urandom;
      endcase
      dest_reg = 5'($urandom);
    end
    start = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("random_completions_seen", 32'(completions > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
